// File: rtl/rename_retire_queue_if.sv
// Bundle of the retire queue's allocation, writeback, commit and flush signals.
// Names keep the _i/_o direction as seen from the queue.
interface rename_retire_queue_if #(
    parameter int ARCH_REG_WIDTH = 5,
    parameter int PHYS_REG_WIDTH = 6,
    parameter int TAG_WIDTH      = 3
);
    logic                      alloc_valid_i;
    logic                      alloc_ready_o;
    logic                      alloc_has_rd_i;
    logic [ARCH_REG_WIDTH-1:0] alloc_rd_arch_i;
    logic [PHYS_REG_WIDTH-1:0] alloc_rd_phys_i;
    logic [TAG_WIDTH-1:0]      alloc_tag_o;
    logic                      wb_valid_i;
    logic [TAG_WIDTH-1:0]      wb_tag_i;
    logic                      commit_valid_o;
    logic                      commit_we_o;
    logic [PHYS_REG_WIDTH-1:0] commit_waddr_o;
    logic [ARCH_REG_WIDTH-1:0] commit_arch_o;
    logic                      flush_i;
    logic [TAG_WIDTH:0]        count_o;

    modport master (
        output alloc_valid_i, alloc_has_rd_i, alloc_rd_arch_i, alloc_rd_phys_i,
        output wb_valid_i, wb_tag_i, flush_i,
        input  alloc_ready_o, alloc_tag_o, commit_valid_o, commit_we_o,
        input  commit_waddr_o, commit_arch_o, count_o
    );

    modport slave (
        input  alloc_valid_i, alloc_has_rd_i, alloc_rd_arch_i, alloc_rd_phys_i,
        input  wb_valid_i, wb_tag_i, flush_i,
        output alloc_ready_o, alloc_tag_o, commit_valid_o, commit_we_o,
        output commit_waddr_o, commit_arch_o, count_o
    );
endinterface

// File: rtl/rename_retire_queue.sv
// In-order retire queue behind the renamer: out-of-order completion by tag, in-order commit/dealloc.
// Optional RETIRE_QUEUE_WB_BYPASS_EN lets a writeback to the head retire in the same cycle.
module rename_retire_queue #(
    parameter int DEPTH          = 8,
    parameter int ARCH_REG_WIDTH = 5,
    parameter int PHYS_REG_WIDTH = 6,
    parameter int TAG_WIDTH      = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    rename_retire_queue_if.slave    q
);

    logic [DEPTH-1:0]          valid_q, valid_d;
    logic [DEPTH-1:0]          done_q, done_d;
    logic [DEPTH-1:0]          has_rd_q;
    logic [ARCH_REG_WIDTH-1:0] arch_q [DEPTH];
    logic [PHYS_REG_WIDTH-1:0] phys_q [DEPTH];
    logic [TAG_WIDTH-1:0]      head_q, head_d;
    logic [TAG_WIDTH-1:0]      tail_q, tail_d;
    logic [TAG_WIDTH:0]        count_q, count_d;

    logic head_done;
    logic retire;
    logic alloc_fire;
    logic wb_ok;

`ifdef RETIRE_QUEUE_WB_BYPASS_EN
    assign head_done = done_q[head_q] | (q.wb_valid_i && (q.wb_tag_i == head_q));
`else
    assign head_done = done_q[head_q];
`endif

    // Flush masks retire and allocation in the same cycle it is presented.
    assign retire     = !q.flush_i && valid_q[head_q] && head_done;
    assign alloc_fire = !q.flush_i && q.alloc_valid_i && q.alloc_ready_o;
    assign wb_ok      = q.wb_valid_i && valid_q[q.wb_tag_i];

    assign q.alloc_ready_o  = (count_q != (TAG_WIDTH+1)'(DEPTH));
    assign q.alloc_tag_o    = tail_q;
    assign q.count_o        = count_q;
    assign q.commit_valid_o = retire;
    assign q.commit_we_o    = retire && has_rd_q[head_q];
    assign q.commit_waddr_o = (retire && has_rd_q[head_q]) ? phys_q[head_q] : '0;
    assign q.commit_arch_o  = retire ? arch_q[head_q] : '0;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (q.flush_i) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wb_ok) done_d[q.wb_tag_i] = 1'b1;
            if (retire) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + TAG_WIDTH'(1);
            end
            // A writeback naming the slot being allocated counts as completion of that entry.
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = q.wb_valid_i && (q.wb_tag_i == tail_q);
                tail_d          = tail_q + TAG_WIDTH'(1);
            end
            case ({alloc_fire, retire})
                2'b10:   count_d = count_q + (TAG_WIDTH+1)'(1);
                2'b01:   count_d = count_q - (TAG_WIDTH+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload is only observed through a valid entry, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            has_rd_q[tail_q] <= q.alloc_has_rd_i;
            arch_q[tail_q]   <= q.alloc_rd_arch_i;
            phys_q[tail_q]   <= q.alloc_rd_phys_i;
        end
    end

endmodule
